pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
- Parametrised program-counter generator for the RISC-V core. It is the successor to the plain PC register.
- Owns the fetch address and presents it to instruction memory with a valid/ready handshake.
- Applies stall, halt/resume, branch and trap redirects with fixed priority, and flags misaligned targets.
- Optionally predicts returns with a small return-address stack.

Parameters:
- DATA_WIDTH, 32, width of PC and all address ports.
- RESET_VECTOR, 32'h0000_0000, PC value loaded by reset.
- INC, 4, sequential step in bytes.
- RAS_DEPTH, 4, return-address stack entries; power of two ≥2; used only with PC_GEN_RAS_EN.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- Stall  in  1  hold PC (pipeline hazard).
- Halt  in  1  enter HALT state.
- Resume  in  1  leave HALT state.
- Branch_Taken  in  1  redirect to Branch_Target.
- Branch_Target  in  DATA_WIDTH  branch/jump destination.
- Trap  in  1  redirect to Trap_Target.
- Trap_Target  in  DATA_WIDTH  trap vector.
- Call_Push  in  1  current fetch is a call; push PC_Plus_Inc.
- Ret_Pop  in  1  current fetch is a return; predict from stack.
- Fetch_Ready  in  1  imem accepts Current_PC.
- Fetch_Valid  out  1  Current_PC is a valid fetch request.
- Current_PC  out  DATA_WIDTH  registered fetch address.
- PC_Plus_Inc  out  DATA_WIDTH  combinational Current_PC + INC.
- Misaligned  out  1  registered one-cycle pulse: branch target not aligned.

Behaviour:
- Reset (rst=0, async):
  - Current_PC=RESET_VECTOR, state=BOOT, Fetch_Valid=0, Misaligned=0, RAS count=0.
- FSM states BOOT, RUN, HALT:
  - BOOT: Fetch_Valid=0 for exactly one cycle after rst deasserts, then RUN. Trap in BOOT is ignored.
  - RUN: Fetch_Valid=1. Halt=1 -> HALT next cycle with PC held. A redirect in the same cycle as Halt still updates PC.
  - HALT: Fetch_Valid=0, PC held. Resume=1 -> RUN. Trap=1 -> PC=Trap_Target and RUN.
- Accept: fetch accepted when Fetch_Valid & Fetch_Ready & !Stall.
- Next-PC priority in RUN (highest first):
  1. Trap -> Trap_Target.
  2. Branch_Taken with Branch_Target[1:0]!=0 -> Trap_Target, Misaligned=1 next cycle.
  3. Branch_Taken -> Branch_Target.
  4. Accept & Ret_Pop & RAS non-empty -> RAS top (macro builds only).
  5. Accept -> PC_Plus_Inc.
  6. Otherwise hold.
- Redirects (1–3) act regardless of Stall and Fetch_Ready and flush the pending request.
- Latency:
  - Redirect seen at cycle N -> Current_PC updated at N+1.
  - PC_Plus_Inc is zero-latency.
- Handshake: while Fetch_Valid=1 and Fetch_Ready=0, Current_PC stays stable unless a redirect occurs.
- Arithmetic: PC + INC is modulo 2^DATA_WIDTH, no carry out. (2^DATA_WIDTH − INC) + INC -> 0.
- Misaligned: asserted only in the cycle after a misaligned taken branch; cleared otherwise. A Trap in the same cycle suppresses it.
- Call_Push and Ret_Pop are sampled only on Accept and ignored otherwise.

Optional Feature:
- Macro PC_GEN_RAS_EN.
- Defined: RAS_DEPTH-entry circular return-address stack with pointer and saturating count.
  - Push on Accept & Call_Push stores PC_Plus_Inc.
  - Push when full overwrites the oldest entry; count stays RAS_DEPTH.
  - Pop on Accept & Ret_Pop with count>0 yields top as next PC and decrements.
  - Pop on empty falls back to sequential.
  - Push & Pop together: top replaced by PC_Plus_Inc, count unchanged, next PC = old top.
  - Trap clears count to 0.
- Undefined: no RAS storage. Call_Push and Ret_Pop ports exist but are ignored; next PC is sequential.

Decomposition:
- Package pc_gen_pkg:
  - pc_state_t enum {BOOT, RUN, HALT}.
  - Next-PC select enum {SEL_TRAP, SEL_MISAL, SEL_BRANCH, SEL_RAS, SEL_SEQ, SEL_HOLD}.
  - ALIGN_MASK constant.
- Sub-module ras_stack (RAS_DEPTH, DATA_WIDTH; push/pop/flush, top, empty) is instantiated only under PC_GEN_RAS_EN.

Test Plan:
- Reset, then rst released with Fetch_Ready=1 -> Current_PC 0x0 and Fetch_Valid=0 for 1 cycle, then 0x0, 0x4, 0x8 on successive cycles.
- Fetch_Ready=0 for 3 cycles at PC 0x8 -> PC holds 0x8. Branch_Taken with target 0x100 during the stall -> PC=0x100 next cycle.
- Branch to 0x102 with Trap_Target=0x80 -> PC=0x80 and Misaligned=1 for one cycle. Simultaneous Trap -> PC=0x80, Misaligned=0.
- Halt at PC 0x20 -> Fetch_Valid=0 and PC=0x20 held 5 cycles. Resume -> Fetch_Valid=1, then PC 0x24.
- PC=0xFFFF_FFFC with Accept -> PC=0x0000_0000.
- With PC_GEN_RAS_EN and RAS_DEPTH=4:
  - Push at 0x10, 0x40, 0x70, 0xA0, 0xD0, then 5 returns -> next PCs 0xD4, 0xA4, 0x74, 0x44, then sequential (entry 0x14 overwritten).

Source files
------------

// File: rtl/pc_gen_pkg.sv
// rtl/pc_gen_pkg.sv - shared FSM states, next-PC selects and alignment mask for pc_gen
package pc_gen_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
  } pc_state_t;

  typedef enum logic [2:0] {
    SEL_TRAP,
    SEL_MISAL,
    SEL_BRANCH,
    SEL_RAS,
    SEL_SEQ,
    SEL_HOLD
  } pc_sel_t;

  // Low address bits that must be zero for a legal 32-bit instruction target
  localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage

// File: rtl/pc_gen_ras_stack.sv
// rtl/pc_gen_ras_stack.sv - circular return-address stack with saturating count
module ras_stack #(
  parameter int RAS_DEPTH  = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] top,
  output logic                  empty
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  logic [DATA_WIDTH-1:0] mem [RAS_DEPTH];
  logic [PTR_W-1:0]      ptr;
  logic [PTR_W-1:0]      top_idx;
  logic [CNT_W-1:0]      count;
  logic                  full;
  logic                  swap;

  // ptr is the next free slot; once full it also addresses the oldest entry
  assign top_idx = ptr - PTR_ONE;
  assign top     = mem[top_idx];
  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  assign swap    = push & pop & ~empty;

  always_ff @(posedge clk) begin
    if (!flush && push) begin
      if (swap) begin
        mem[top_idx] <= din;
      end else begin
        mem[ptr] <= din;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr   <= '0;
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (swap) begin
      ptr   <= ptr;
    end else if (push) begin
      ptr <= ptr + PTR_ONE;
      if (!full) begin
        count <= count + CNT_ONE;
      end
    end else if (pop && !empty) begin
      ptr   <= top_idx;
      count <= count - CNT_ONE;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch program-counter generator; return-address stack enabled by PC_GEN_RAS_EN
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter int                    INC          = 4,
  parameter int                    RAS_DEPTH    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Stall,
  input  logic                  Halt,
  input  logic                  Resume,
  input  logic                  Branch_Taken,
  input  logic [DATA_WIDTH-1:0] Branch_Target,
  input  logic                  Trap,
  input  logic [DATA_WIDTH-1:0] Trap_Target,
  input  logic                  Call_Push,
  input  logic                  Ret_Pop,
  input  logic                  Fetch_Ready,
  output logic                  Fetch_Valid,
  output logic [DATA_WIDTH-1:0] Current_PC,
  output logic [DATA_WIDTH-1:0] PC_Plus_Inc,
  output logic                  Misaligned
);

  pc_state_t             state;
  pc_sel_t               sel;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] pc_next;
  logic [DATA_WIDTH-1:0] ras_top;
  logic                  fv_q;
  logic                  mis_q;
  logic                  accept;
  logic                  adv;
  logic                  br_misal;
  logic                  ras_empty;
  logic                  ras_hit;

  assign Current_PC  = pc_q;
  assign Fetch_Valid = fv_q;
  assign Misaligned  = mis_q;
  assign PC_Plus_Inc = pc_q + DATA_WIDTH'(INC);

  assign accept   = fv_q & Fetch_Ready & ~Stall;
  // A halting or redirected cycle does not consume the fetch, so the stack is left alone too
  assign adv      = accept & ~Halt & ~Trap & ~Branch_Taken;
  assign br_misal = Branch_Taken & ((Branch_Target[1:0] & ALIGN_MASK) != 2'b00);
  assign ras_hit  = Ret_Pop & ~ras_empty;

`ifdef PC_GEN_RAS_EN
  ras_stack #(
    .RAS_DEPTH  (RAS_DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ras (
    .clk   (clk),
    .rst   (rst),
    .push  (adv & Call_Push),
    .pop   (adv & Ret_Pop),
    .flush (sel == SEL_TRAP),
    .din   (PC_Plus_Inc),
    .top   (ras_top),
    .empty (ras_empty)
  );
`else
  localparam int unused_ras_depth = RAS_DEPTH;
  logic unused_call;
  assign unused_call = Call_Push;
  assign ras_top     = '0;
  assign ras_empty   = 1'b1;
`endif

  always_comb begin
    sel = SEL_HOLD;
    case (state)
      RUN: begin
        if (Trap)                sel = SEL_TRAP;
        else if (br_misal)       sel = SEL_MISAL;
        else if (Branch_Taken)   sel = SEL_BRANCH;
        else if (adv && ras_hit) sel = SEL_RAS;
        else if (adv)            sel = SEL_SEQ;
      end
      HALT: begin
        if (Trap) sel = SEL_TRAP;
      end
      default: sel = SEL_HOLD;
    endcase
  end

  always_comb begin
    pc_next = pc_q;
    case (sel)
      SEL_TRAP:   pc_next = Trap_Target;
      SEL_MISAL:  pc_next = Trap_Target;
      SEL_BRANCH: pc_next = Branch_Target;
      SEL_RAS:    pc_next = ras_top;
      SEL_SEQ:    pc_next = PC_Plus_Inc;
      default:    pc_next = pc_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= BOOT;
      pc_q  <= RESET_VECTOR;
      fv_q  <= 1'b0;
      mis_q <= 1'b0;
    end else begin
      pc_q  <= pc_next;
      mis_q <= (sel == SEL_MISAL);
      case (state)
        BOOT: begin
          state <= RUN;
          fv_q  <= 1'b1;
        end
        RUN: begin
          if (Halt) begin
            state <= HALT;
            fv_q  <= 1'b0;
          end
        end
        HALT: begin
          if (Trap || Resume) begin
            state <= RUN;
            fv_q  <= 1'b1;
          end
        end
        default: begin
          state <= BOOT;
          fv_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - directed and randomized check of pc_gen against a behavioural model
module tb_pc_gen;

  localparam int W      = 32;
  localparam int INC    = 4;
  localparam int DEPTH  = 4;
  localparam int M_BOOT = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         Stall, Halt, Resume, Branch_Taken, Trap, Call_Push, Ret_Pop, Fetch_Ready;
  logic [W-1:0] Branch_Target, Trap_Target;
  logic         Fetch_Valid, Misaligned;
  logic [W-1:0] Current_PC, PC_Plus_Inc;

  always #5 clk = ~clk;

  pc_gen #(
    .DATA_WIDTH   (W),
    .RESET_VECTOR (32'h0000_0000),
    .INC          (INC),
    .RAS_DEPTH    (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .Stall         (Stall),
    .Halt          (Halt),
    .Resume        (Resume),
    .Branch_Taken  (Branch_Taken),
    .Branch_Target (Branch_Target),
    .Trap          (Trap),
    .Trap_Target   (Trap_Target),
    .Call_Push     (Call_Push),
    .Ret_Pop       (Ret_Pop),
    .Fetch_Ready   (Fetch_Ready),
    .Fetch_Valid   (Fetch_Valid),
    .Current_PC    (Current_PC),
    .PC_Plus_Inc   (PC_Plus_Inc),
    .Misaligned    (Misaligned)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int           mode;
  logic [W-1:0] m_pc;
  logic         m_mis;
  logic [W-1:0] ras_q [$];

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: applies the next-PC rules to the inputs currently driven
  task automatic model_step();
    logic [W-1:0] seq;
    bit           take;
    seq   = m_pc + INC;
    m_mis = 1'b0;
    if (mode == M_BOOT) begin
      mode = M_RUN;
    end else if (mode == M_HALT) begin
      if (Trap) begin
        m_pc = Trap_Target;
        ras_q.delete();
        mode = M_RUN;
      end else if (Resume) begin
        mode = M_RUN;
      end
    end else begin
      take = Fetch_Ready && !Stall && !Halt;
      if (Trap) begin
        m_pc = Trap_Target;
        ras_q.delete();
      end else if (Branch_Taken && Branch_Target[1:0] != 2'b00) begin
        m_pc  = Trap_Target;
        m_mis = 1'b1;
      end else if (Branch_Taken) begin
        m_pc = Branch_Target;
      end else if (take) begin
        m_pc = seq;
`ifdef PC_GEN_RAS_EN
        if (Ret_Pop && ras_q.size() > 0) begin
          m_pc = ras_q[ras_q.size()-1];
          if (Call_Push) ras_q[ras_q.size()-1] = seq;
          else void'(ras_q.pop_back());
        end else if (Call_Push) begin
          ras_q.push_back(seq);
          if (ras_q.size() > DEPTH) void'(ras_q.pop_front());
        end
`endif
      end
      if (Halt) mode = M_HALT;
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("pc", Current_PC, m_pc);
    check("fetch_valid", {31'b0, Fetch_Valid}, {31'b0, mode == M_RUN});
    check("misaligned", {31'b0, Misaligned}, {31'b0, m_mis});
    check("pc_plus_inc", PC_Plus_Inc, m_pc + INC);
  endtask

  task automatic idle();
    Stall = 0; Halt = 0; Resume = 0; Branch_Taken = 0; Trap = 0;
    Call_Push = 0; Ret_Pop = 0; Fetch_Ready = 1;
    Branch_Target = '0; Trap_Target = '0;
  endtask

  task automatic branch_to(input logic [W-1:0] t);
    Branch_Taken = 1; Branch_Target = t;
    cycle();
    Branch_Taken = 0;
  endtask

  function automatic logic [W-1:0] rand_target();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return ($urandom & 32'h0000_0FFC) | W'($urandom_range(1, 3));
    if (r == 1) return 32'hFFFF_FFF0 + W'($urandom_range(0, 3) * 4);
    return $urandom & 32'h0000_0FFC;
  endfunction

  initial begin
    logic [W-1:0] push_pcs [5];
    logic [W-1:0] ret_exp  [5];
    push_pcs = '{32'h10, 32'h40, 32'h70, 32'hA0, 32'hD0};
`ifdef PC_GEN_RAS_EN
    ret_exp = '{32'hD4, 32'hA4, 32'h74, 32'h44, 32'h48};
`else
    ret_exp = '{32'hD8, 32'hDC, 32'hE0, 32'hE4, 32'hE8};
`endif
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("reset_pc", Current_PC, 32'h0);
    check("reset_fv", {31'b0, Fetch_Valid}, 32'h0);
    check("reset_mis", {31'b0, Misaligned}, 32'h0);
    mode = M_BOOT; m_pc = 32'h0; m_mis = 0; ras_q.delete();
    rst = 1;

    cycle();
    check("boot_done_pc", Current_PC, 32'h0);
    cycle();
    cycle();
    check("seq_8", Current_PC, 32'h8);

    Fetch_Ready = 0;
    repeat (3) cycle();
    check("hold_8", Current_PC, 32'h8);
    branch_to(32'h100);
    check("branch_in_stall", Current_PC, 32'h100);
    Fetch_Ready = 1;

    Trap_Target = 32'h80;
    branch_to(32'h102);
    check("misal_pc", Current_PC, 32'h80);
    check("misal_pulse", {31'b0, Misaligned}, 32'h1);
    cycle();
    check("misal_clear", {31'b0, Misaligned}, 32'h0);
    Trap = 1;
    branch_to(32'h102);
    Trap = 0;
    check("trap_misal_pc", Current_PC, 32'h80);
    check("trap_misal_suppr", {31'b0, Misaligned}, 32'h0);

    branch_to(32'h20);
    Halt = 1;
    cycle();
    Halt = 0;
    repeat (4) cycle();
    check("halt_pc", Current_PC, 32'h20);
    check("halt_fv", {31'b0, Fetch_Valid}, 32'h0);
    Resume = 1;
    cycle();
    Resume = 0;
    check("resume_fv", {31'b0, Fetch_Valid}, 32'h1);
    cycle();
    check("resume_seq", Current_PC, 32'h24);

    branch_to(32'hFFFF_FFFC);
    check("wrap_plus", PC_Plus_Inc, 32'h0);
    cycle();
    check("wrap_pc", Current_PC, 32'h0);

    for (int i = 0; i < 5; i++) begin
      branch_to(push_pcs[i]);
      Call_Push = 1;
      cycle();
      Call_Push = 0;
    end
    Ret_Pop = 1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("ret_seq", Current_PC, ret_exp[i]);
    end
    Ret_Pop = 0;

    for (int i = 0; i < 3000; i++) begin
      Stall         = ($urandom_range(0, 99) < 15);
      Halt          = ($urandom_range(0, 99) < 4);
      Resume        = ($urandom_range(0, 99) < 30);
      Trap          = ($urandom_range(0, 99) < 3);
      Branch_Taken  = ($urandom_range(0, 99) < 8);
      Branch_Target = rand_target();
      Trap_Target   = $urandom & 32'hFFFF_FFFC;
      Call_Push     = ($urandom_range(0, 99) < 20);
      Ret_Pop       = ($urandom_range(0, 99) < 20);
      Fetch_Ready   = ($urandom_range(0, 99) < 75);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
